// File: rtl/mux_reg_pkg.sv
// Shared constants and helpers for the multiplexed register bank.
package mux_reg_pkg;

    localparam int MRB_MAX_DEPTH = 64;
    localparam int MRB_DEF_WIDTH = 8;

    // Read-select width for a given depth; a two-entry bank still needs one bit.
    function automatic int mrb_sel_w(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mux_reg_cell.sv
// One WIDTH-bit register of the bank: parallel load in functional mode,
// serial shift (LSB in, MSB out) in scan mode, asynchronous clear.
module mux_reg_cell
    import mux_reg_pkg::*;
#(
    parameter int WIDTH = MRB_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tc,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shift_next;

    // Scan shift moves every bit one place toward the MSB, taking si at bit 0.
    generate
        if (WIDTH == 1) begin : g_single
            assign shift_next = si;
        end else begin : g_multi
            assign shift_next = {q_reg[WIDTH-2:0], si};
        end
    endgenerate

    // Scan mode has priority over the functional load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (tc) begin
            q_reg <= shift_next;
        end else if (ld) begin
            q_reg <= d;
        end
    end

    assign q  = q_reg;
    assign so = q_reg[WIDTH-1];

endmodule

// File: rtl/mux_reg_bank.sv
// Parametrised bank of DEPTH x WIDTH registers with multi-hot write enable,
// indexed read mux, optional registered output and a full-length scan chain.
module mux_reg_bank
    import mux_reg_pkg::*;
#(
    parameter int WIDTH   = MRB_DEF_WIDTH,
    parameter int DEPTH   = 8,
    parameter int SEL_W   = mrb_sel_w(DEPTH),
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [DEPTH-1:0] en_in,
    input  logic [SEL_W-1:0] en_out,
    input  logic             rd_en,
    output logic [WIDTH-1:0] out,
    input  logic             tc,
    input  logic             td,
    output logic             tq
);

    // Depth widened by one bit so the range test is meaningful for every DEPTH.
    localparam logic [SEL_W:0] DEPTH_EXT = (SEL_W + 1)'(DEPTH);

    logic [WIDTH-1:0] cell_q [DEPTH];
    logic [DEPTH:0]   scan_link;
    logic [WIDTH-1:0] rdata;

    assign scan_link[0] = td;

    // Cell gi takes its scan input from the MSB of cell gi-1 (TD for cell 0).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            mux_reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .tc    (tc),
                .ld    (en_in[gi]),
                .d     (in),
                .si    (scan_link[gi]),
                .q     (cell_q[gi]),
                .so    (scan_link[gi+1])
            );
        end
    endgenerate

    // Scan output is the MSB of the last register, visible in both modes.
    assign tq = scan_link[DEPTH];

    // Read mux; indices past the last register read as zero.
    always_comb begin
        rdata = '0;
        if ({1'b0, en_out} < DEPTH_EXT) begin
            rdata = cell_q[en_out];
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] out_reg;

            // Output stage captures pre-edge contents; frozen while scanning.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                end else if (!tc && rd_en) begin
                    out_reg <= rdata;
                end
            end

            assign out = out_reg;
        end else begin : g_comb_out
            logic unused_rd_en;
            assign unused_rd_en = rd_en;
            assign out          = rdata;
        end
    endgenerate

endmodule

// File: tb/tb_mux_reg_bank.sv
// Self-checking bench: default bank (8x8, registered output) and a 5x12
// combinational-output bank, both compared against array/bit-vector models.
module tb_mux_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  in;
    logic [7:0]  en_in;
    logic [2:0]  en_out;
    logic        rd_en;
    logic        tc;
    logic        td;
    logic [7:0]  out;
    logic        tq;

    logic [11:0] in2;
    logic [4:0]  en_in2;
    logic [2:0]  en_out2;
    logic        rd_en2;
    logic        tc2;
    logic        td2;
    logic [11:0] out2;
    logic        tq2;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m [8];
    logic [7:0]  m_out;
    logic [11:0] m2 [5];

    always #5 clk = ~clk;

    mux_reg_bank #(.WIDTH(8), .DEPTH(8), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .en_in(en_in), .en_out(en_out),
        .rd_en(rd_en), .out(out), .tc(tc), .td(td), .tq(tq)
    );

    mux_reg_bank #(.WIDTH(12), .DEPTH(5), .REG_OUT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .en_in(en_in2), .en_out(en_out2),
        .rd_en(rd_en2), .out(out2), .tc(tc2), .td(td2), .tq(tq2)
    );

    function automatic logic [11:0] rd2(input logic [2:0] idx);
        if (idx < 3'd5) return m2[idx];
        return 12'h000;
    endfunction

    function automatic logic [63:0] pack1();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = m[i];
        return v;
    endfunction

    function automatic logic [59:0] pack2();
        logic [59:0] v;
        for (int i = 0; i < 5; i++) v[i*12 +: 12] = m2[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        for (int i = 0; i < 5; i++) m2[i] = 12'h000;
        m_out = 8'h00;
    endtask

    // Advance both models by one clock edge using the currently driven inputs,
    // then let the edge happen and return 1 time unit after it.
    task automatic step();
        logic [63:0] v;
        logic [59:0] v2;
        logic [7:0]  rd;
        if (tc) begin
            v = pack1();
            v = {v[62:0], td};
            for (int i = 0; i < 8; i++) m[i] = v[i*8 +: 8];
        end else begin
            rd = m[en_out];
            for (int i = 0; i < 8; i++) if (en_in[i]) m[i] = in;
            if (rd_en) m_out = rd;
        end
        if (tc2) begin
            v2 = pack2();
            v2 = {v2[58:0], td2};
            for (int i = 0; i < 5; i++) m2[i] = v2[i*12 +: 12];
        end else begin
            for (int i = 0; i < 5; i++) if (en_in2[i]) m2[i] = in2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in = 8'h00; en_in = 8'h00; en_out = 3'd0; rd_en = 1'b0; tc = 1'b0; td = 1'b0;
        in2 = 12'h000; en_in2 = 5'h00; en_out2 = 3'd0; rd_en2 = 1'b0; tc2 = 1'b0; td2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in = 8'hFF; en_in = 8'hFF; tc = 1'b1; td = 1'b1; rd_en = 1'b1;
        in2 = 12'hFFF; en_in2 = 5'h1F; tc2 = 1'b0; en_out2 = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        checks++;
        if (tq !== 1'b0) begin errors++; $display("FAIL reset_tq: got %b expected 0", tq); end
        checks++;
        if (out2 !== 12'h000) begin errors++; $display("FAIL reset_out2: got %h expected 000", out2); end
        idle_inputs();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_out = 3'(i); rd_en = 1'b1;
            step();
            checks++;
            if (out !== 8'h00) begin errors++; $display("FAIL reset_read idx=%0d: got %h expected 00", i, out); end
        end
        rd_en = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        in = 8'hA5; en_in = 8'h08;
        step();
        en_in = 8'h00; en_out = 3'd3; rd_en = 1'b1;
        step();
        checks++;
        if (out !== 8'hA5) begin errors++; $display("FAIL write_read idx=3: got %h expected a5", out); end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) continue;
            en_out = 3'(i);
            step();
            checks++;
            if (out !== 8'h00) begin errors++; $display("FAIL write_read idx=%0d: got %h expected 00", i, out); end
        end
        rd_en = 1'b0;
        $display("test_write_read done");
    endtask

    task automatic test_multi_hot();
        in = 8'h3C; en_in = 8'hFF;
        step();
        en_in = 8'h00; rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_out = 3'(i);
            step();
            checks++;
            if (out !== 8'h3C) begin errors++; $display("FAIL multi_hot_all idx=%0d: got %h expected 3c", i, out); end
        end
        rd_en = 1'b0; in = 8'h11; en_in = 8'h01;
        step();
        en_in = 8'h00; rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_v;
            exp_v = (i == 0) ? 8'h11 : 8'h3C;
            en_out = 3'(i);
            step();
            checks++;
            if (out !== exp_v) begin errors++; $display("FAIL multi_hot_one idx=%0d: got %h expected %h", i, out, exp_v); end
        end
        rd_en = 1'b0;
        $display("test_multi_hot done");
    endtask

    task automatic test_same_cycle();
        in = 8'h22; en_in = 8'h20; rd_en = 1'b0;
        step();
        in = 8'h77; en_in = 8'h20; en_out = 3'd5; rd_en = 1'b1;
        step();
        checks++;
        if (out !== 8'h22) begin errors++; $display("FAIL same_cycle_old: got %h expected 22", out); end
        en_in = 8'h00; rd_en = 1'b0;
        step();
        checks++;
        if (out !== 8'h22) begin errors++; $display("FAIL same_cycle_hold: got %h expected 22", out); end
        rd_en = 1'b1;
        step();
        checks++;
        if (out !== 8'h77) begin errors++; $display("FAIL same_cycle_new: got %h expected 77", out); end
        rd_en = 1'b0;
        $display("test_same_cycle done");
    endtask

    task automatic test_scan();
        logic [63:0] pat;
        logic [7:0]  held;
        pat  = 64'h0123_4567_89AB_CDEF;
        held = m_out;
        tc = 1'b1;
        for (int k = 0; k < 64; k++) begin
            td = pat[k]; en_in = 8'($urandom); in = 8'($urandom); rd_en = 1'($urandom);
            step();
            checks++;
            if (tq !== m[7][7]) begin errors++; $display("FAIL scan_in_tq k=%0d: got %b expected %b", k, tq, m[7][7]); end
        end
        checks++;
        if (out !== held) begin errors++; $display("FAIL scan_out_hold: got %h expected %h", out, held); end
        tc = 1'b0; en_in = 8'h00; rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_out = 3'(i);
            step();
            checks++;
            if (out !== m_out) begin errors++; $display("FAIL scan_regs idx=%0d: got %h expected %h", i, out, m_out); end
        end
        rd_en = 1'b0; tc = 1'b1;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (tq !== pat[k]) begin errors++; $display("FAIL scan_tq k=%0d: got %b expected %b", k, tq, pat[k]); end
            td = 1'b0; en_in = 8'($urandom);
            step();
        end
        tc = 1'b0; en_in = 8'h00;
        $display("test_scan done");
    endtask

    task automatic test_async_reset();
        in = 8'hFF; en_in = 8'hFF; in2 = 12'hFFF; en_in2 = 5'h1F;
        step();
        en_in = 8'h00; en_in2 = 5'h00; en_out = 3'd2; rd_en = 1'b1; en_out2 = 3'd4;
        step();
        rd_en = 1'b0; tc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            td = 1'($urandom);
            step();
        end
        checks++;
        if (tq !== m[7][7] || out !== m_out) begin
            errors++; $display("FAIL pre_reset: got out=%h tq=%b expected out=%h tq=%b", out, tq, m_out, m[7][7]);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL async_out: got %h expected 00", out); end
        checks++;
        if (tq !== 1'b0) begin errors++; $display("FAIL async_tq: got %b expected 0", tq); end
        checks++;
        if (out2 !== 12'h000) begin errors++; $display("FAIL async_out2: got %h expected 000", out2); end
        rst_n = 1'b1;
        tc = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_out = 3'(i);
            step();
            checks++;
            if (out !== 8'h00) begin errors++; $display("FAIL async_regs idx=%0d: got %h expected 00", i, out); end
        end
        rd_en = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_sweep();
        logic [59:0] p2;
        en_out2 = 3'd6;
        #1;
        checks++;
        if (out2 !== 12'h000) begin errors++; $display("FAIL sweep_oor: got %h expected 000", out2); end
        en_out2 = 3'd4; in2 = 12'hABC; en_in2 = 5'h10;
        #1;
        checks++;
        if (out2 !== rd2(3'd4)) begin errors++; $display("FAIL sweep_pre_write: got %h expected %h", out2, rd2(3'd4)); end
        step();
        en_in2 = 5'h00;
        checks++;
        if (out2 !== 12'hABC) begin errors++; $display("FAIL sweep_write: got %h expected abc", out2); end
        p2 = 60'({$urandom, $urandom});
        tc2 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            td2 = p2[k];
            step();
        end
        for (int k = 0; k < 60; k++) begin
            checks++;
            if (tq2 !== p2[k]) begin errors++; $display("FAIL sweep_chain k=%0d: got %b expected %b", k, tq2, p2[k]); end
            td2 = 1'b0;
            step();
        end
        tc2 = 1'b0;
        $display("test_sweep done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in = 8'($urandom); en_in = 8'($urandom); en_out = 3'($urandom);
            rd_en = 1'($urandom); tc = ($urandom_range(0, 7) == 0); td = 1'($urandom);
            in2 = 12'($urandom); en_in2 = 5'($urandom); en_out2 = 3'($urandom);
            rd_en2 = 1'($urandom); tc2 = ($urandom_range(0, 7) == 0); td2 = 1'($urandom);
            step();
            checks++;
            if (out !== m_out || tq !== m[7][7]) begin
                errors++; $display("FAIL random_a n=%0d: got out=%h tq=%b expected out=%h tq=%b", n, out, tq, m_out, m[7][7]);
            end
            checks++;
            if (out2 !== rd2(en_out2) || tq2 !== m2[4][11]) begin
                errors++; $display("FAIL random_b n=%0d: got out=%h tq=%b expected out=%h tq=%b", n, out2, tq2, rd2(en_out2), m2[4][11]);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read();
        test_multi_hot();
        test_same_cycle();
        test_scan();
        test_async_reset();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
